// File: rtl/vmem_write_arbiter.sv
// vmem_write_arbiter
//   CPU-side writer/arbiter for the shared video memory. Video fetches own the
//   RAM whenever vid_active is high. CPU writes are queued in a small FIFO and
//   retire in idle slots. CPU reads wait until every queued write has retired.
//   Optional feature macro: VMEM_CPU_READ_EN enables the CPU read path and its
//   FSM. When the macro is undefined the read ports stay present and are tied
//   off.
module vmem_write_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vid_active,
    input  logic [ADDR_W-1:0]             vid_addr,
    output logic [DATA_W-1:0]             vid_data,
    input  logic                          cpu_wr_valid,
    output logic                          cpu_wr_ready,
    input  logic [ADDR_W-1:0]             cpu_wr_addr,
    input  logic [DATA_W-1:0]             cpu_wr_data,
    input  logic                          cpu_rd_valid,
    output logic                          cpu_rd_ready,
    input  logic [ADDR_W-1:0]             cpu_rd_addr,
    output logic                          cpu_rd_dvalid,
    output logic [DATA_W-1:0]             cpu_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_wren,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              rd_issue;

    // A full FIFO refuses a push even in a cycle where it also pops.
    assign fifo_empty   = (level_q == '0);
    assign cpu_wr_ready = (level_q < DEPTH_LVL);
    assign push         = cpu_wr_valid && cpu_wr_ready;
    assign pop          = !vid_active && !fifo_empty;
    assign fifo_level   = level_q;
    assign vid_data     = mem_rdata;

    // Next FIFO pointers and level; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO bookkeeping registers; reset discards all queued writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO payload storage, written on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only read after a push has written it.
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_wr_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wr_data;
        end
    end

`ifdef VMEM_CPU_READ_EN
    typedef enum logic {ST_IDLE, ST_RD_WAIT} rd_state_e;

    rd_state_e         state_q, state_d;
    logic              rd_capture;
    logic              rd_dvalid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Read FSM state register; an in-flight read is dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Read FSM next state: a single wait cycle while the RAM output register fills.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (rd_issue) state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read FSM outputs: reads only issue into an idle RAM with no writes queued.
    always_comb begin
        cpu_rd_ready = (state_q == ST_IDLE) && !vid_active && fifo_empty;
        rd_issue     = cpu_rd_ready && cpu_rd_valid;
        rd_capture   = (state_q == ST_RD_WAIT);
    end

    // Capture the RAM output one cycle after issue and pulse the data-valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dvalid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_dvalid_q <= rd_capture;
            if (rd_capture) rd_data_q <= mem_rdata;
        end
    end

    assign cpu_rd_dvalid = rd_dvalid_q;
    assign cpu_rd_data   = rd_data_q;
`else
    logic unused_rd;

    assign unused_rd     = ^{cpu_rd_valid, cpu_rd_addr};
    assign rd_issue      = 1'b0;
    assign cpu_rd_ready  = 1'b0;
    assign cpu_rd_dvalid = 1'b0;
    assign cpu_rd_data   = '0;
`endif

    // RAM port mux: video fetch, then FIFO drain, then CPU read issue.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (vid_active) begin
            mem_addr = vid_addr;
        end else if (!fifo_empty) begin
            mem_addr  = fifo_addr_q[rd_ptr_q];
            mem_wdata = fifo_data_q[rd_ptr_q];
            mem_wren  = 1'b1;
        end else if (rd_issue) begin
            mem_addr = cpu_rd_addr;
        end
    end

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// tb_vmem_write_arbiter
//   Directed scenarios followed by random traffic, checked every cycle against a
//   queue-based model of the arbitration rules and a behavioural RAM.
//   The read-path scenarios follow the VMEM_CPU_READ_EN macro.
module tb_vmem_write_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 4;
`ifdef VMEM_CPU_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              vid_active;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_rd_valid;
    logic              cpu_rd_ready;
    logic [ADDR_W-1:0] cpu_rd_addr;
    logic              cpu_rd_dvalid;
    logic [DATA_W-1:0] cpu_rd_data;
    logic [2:0]        fifo_level;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;

    vmem_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .vid_active(vid_active), .vid_addr(vid_addr), .vid_data(vid_data),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_ready(cpu_rd_ready),
        .cpu_rd_addr(cpu_rd_addr), .cpu_rd_dvalid(cpu_rd_dvalid),
        .cpu_rd_data(cpu_rd_data), .fifo_level(fifo_level),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered output, read-before-write.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               wq[$];
    logic [DATA_W-1:0] shadow [int];
    int                rd_stage;
    logic [DATA_W-1:0] rd_pend;
    logic [DATA_W-1:0] rd_hold;
    bit                rd_acc;
    bit                vd_known;
    logic [DATA_W-1:0] vd_exp;
    int                checks;
    int                errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        logic              exp_wren;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        logic              exp_rd_ready;
        bit                push;
        wr_t               w;
        @(negedge clk);
        exp_wren     = 1'b0;
        exp_addr     = '0;
        exp_wdata    = '0;
        exp_rd_ready = READ_EN && (rd_stage != 1) && !vid_active && (wq.size() == 0);
        if (vid_active) begin
            exp_addr = vid_addr;
        end else if (wq.size() != 0) begin
            exp_wren  = 1'b1;
            exp_addr  = wq[0].a;
            exp_wdata = wq[0].d;
        end else if (exp_rd_ready && cpu_rd_valid) begin
            exp_addr = cpu_rd_addr;
        end
        check("mem_wren", mem_wren, exp_wren);
        check("mem_addr", mem_addr, exp_addr);
        if (exp_wren) check("mem_wdata", mem_wdata, exp_wdata);
        check("cpu_wr_ready", cpu_wr_ready, wq.size() < DEPTH);
        check("fifo_level", fifo_level, wq.size());
        check("cpu_rd_ready", cpu_rd_ready, exp_rd_ready);
        check("cpu_rd_dvalid", cpu_rd_dvalid, rd_stage == 2);
        check("cpu_rd_data", cpu_rd_data, rd_hold);
        if (vd_known) check("vid_data", vid_data, vd_exp);

        vd_known = shadow.exists(int'(exp_addr));
        if (vd_known) vd_exp = shadow[int'(exp_addr)];
        push   = cpu_wr_valid && (wq.size() < DEPTH);
        rd_acc = exp_rd_ready && cpu_rd_valid;

        if (rd_stage == 1) rd_hold = rd_pend;
        if (rd_acc) begin
            rd_pend  = shadow.exists(int'(cpu_rd_addr)) ? shadow[int'(cpu_rd_addr)] : 'x;
            rd_stage = 1;
        end else begin
            rd_stage = (rd_stage == 1) ? 2 : 0;
        end
        if (exp_wren) begin
            shadow[int'(wq[0].a)] = wq[0].d;
            void'(wq.pop_front());
        end
        if (push) begin
            w.a = cpu_wr_addr;
            w.d = cpu_wr_data;
            wq.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle and check the FIFO clears without waiting for a clock.
    task automatic apply_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_fifo_level", fifo_level, 0);
        check("rst_wr_ready", cpu_wr_ready, 1);
        check("rst_rd_dvalid", cpu_rd_dvalid, 0);
        wq.delete();
        rd_stage = 0;
        rd_hold  = '0;
        vd_known = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drive_wr(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_wr_valid = v;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
    endtask

    initial begin
        bit accepted;
        checks       = 0;
        errors       = 0;
        rd_stage     = 0;
        rd_pend      = '0;
        rd_hold      = '0;
        rd_acc       = 1'b0;
        vd_known     = 1'b0;
        vd_exp       = '0;
        rst          = 1'b0;
        vid_active   = 1'b0;
        vid_addr     = '0;
        cpu_rd_valid = 1'b0;
        cpu_rd_addr  = '0;
        drive_wr(1'b0, '0, '0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_fifo_level", fifo_level, 0);
        check("reset_mem_wren", mem_wren, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rd_dvalid", cpu_rd_dvalid, 0);
        check("reset_rd_data", cpu_rd_data, 0);
        check("reset_wr_ready", cpu_wr_ready, 1);
        rst = 1'b1;

        // Three back-to-back writes drain in order in consecutive cycles.
        drive_wr(1'b1, 14'h0010, 12'hABC); cycle();
        drive_wr(1'b1, 14'h0011, 12'h123); cycle();
        drive_wr(1'b1, 14'h0012, 12'h456); cycle();
        drive_wr(1'b0, '0, '0);
        repeat (4) cycle();
        check("t1_level_end", fifo_level, 0);

        // Video window: four writes accepted, fifth refused, all drain afterwards.
        vid_active = 1'b1;
        vid_addr   = 14'h0010;
        for (int i = 0; i < 20; i++) begin
            if (i < 5) drive_wr(1'b1, 14'h0020 + 14'(i), 12'h100 + 12'(i));
            else       drive_wr(1'b0, '0, '0);
            cycle();
        end
        check("t2_full_ready", cpu_wr_ready, 0);
        check("t2_full_level", fifo_level, 4);
        vid_active = 1'b0;
        repeat (6) cycle();

        // Video fetch returns RAM contents one cycle after the address.
        drive_wr(1'b1, 14'h3040, 12'h7E1); cycle();
        drive_wr(1'b0, '0, '0);
        repeat (2) cycle();
        vid_active = 1'b1;
        vid_addr   = 14'h3040;
        cycle();
        check("t3_vid_data", vid_data, 12'h7E1);
        cycle();
        vid_active = 1'b0;

`ifdef VMEM_CPU_READ_EN
        // Read of a just-queued write waits for the window and the drain.
        vid_active   = 1'b1;
        drive_wr(1'b1, 14'h1234, 12'h5A5);
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 14'h1234;
        cycle();
        drive_wr(1'b0, '0, '0);
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (i == 3) vid_active = 1'b0;
            cycle();
            accepted = rd_acc;
        end
        check("t4_read_accepted", accepted, 1);
        cpu_rd_valid = 1'b0;
        cycle();
        check("t4_rd_dvalid", cpu_rd_dvalid, 1);
        check("t4_rd_data", cpu_rd_data, 12'h5A5);
        cycle();
`else
        // Read path absent: requests are never accepted.
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 14'h0010;
        repeat (10) cycle();
        cpu_rd_valid = 1'b0;
`endif

        // Reset with writes queued: nothing retires afterwards.
        vid_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_wr(1'b1, 14'h0040 + 14'(i), 12'h200 + 12'(i));
            cycle();
        end
        drive_wr(1'b0, '0, '0);
        cycle();
        apply_reset();
        vid_active = 1'b0;
        repeat (5) cycle();

        // Fill a small address window so random reads and fetches have known data.
        for (int i = 0; i < 16; i++) begin
            drive_wr(1'b1, 14'h0100 + 14'(i), 12'($urandom));
            cycle();
        end
        drive_wr(1'b0, '0, '0);
        repeat (2) cycle();

        // Random traffic over the same window.
        for (int i = 0; i < 600; i++) begin
            vid_active = ($urandom_range(0, 2) == 0);
            vid_addr   = 14'h0100 + 14'($urandom_range(0, 15));
            drive_wr(1'($urandom_range(0, 1)), 14'h0100 + 14'($urandom_range(0, 15)), 12'($urandom));
            cpu_rd_valid = READ_EN && ($urandom_range(0, 1) == 1);
            cpu_rd_addr  = 14'h0100 + 14'($urandom_range(0, 15));
            cycle();
        end
        vid_active   = 1'b0;
        cpu_rd_valid = 1'b0;
        drive_wr(1'b0, '0, '0);
        repeat (8) cycle();
        check("final_level", fifo_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
